clk_enable_gen: RTL and testbench
=================================

# clk_enable_gen

Multi-channel, programmable clock-enable generator and successor to the single-output ripple divider. All logic runs on one clock: each channel produces a one-cycle `tick` enable pulse and a 50%-duty `tog` level rather than a derived clock. Each channel's divide ratio and run state are written at runtime through a small config port. A `sync` strobe phase-aligns all running channels. It sits beside the top-level clock input and feeds enables to slow logic such as the display refresh, debouncers and the single-step CPU clock.

## Interface
- `NUM_CH`, default 2: number of independent channels, at least 1.
- `CNT_W`, default 28: counter and divisor width.
- `DEFAULT_DIV`, default 49_999_999: terminal count loaded at reset (1 Hz tick at 100 MHz).
- `clk`, input, 1: sole clock. All outputs are registered.
- `reset`, input, 1: asynchronous, active-high.
- `cfg_we`, input, 1: config write strobe, sampled on the rising edge of `clk`.
- `cfg_ch`, input, CH_W = max(1, $clog2(NUM_CH)): target channel.
- `cfg_div`, input, CNT_W: new terminal count.
- `cfg_en`, input, 1: new run bit for the channel.
- `sync`, input, 1: restart all running channels in phase.
- `tick`, output, NUM_CH: one-cycle enable pulse per channel.
- `tog`, output, NUM_CH: toggles on every tick of that channel.
- `running`, output, NUM_CH: current run bit per channel.

## Operation
- Per-channel state:
  - `div_r` (CNT_W), reset to DEFAULT_DIV.
  - `cnt` (CNT_W), reset to DEFAULT_DIV.
  - `en_r`, reset to 1.
  - `tick`, reset to 0.
  - `tog`, reset to 0.
- Reset leaves every channel running at DEFAULT_DIV, matching the power-up behaviour of the old divider.
- Running channel (`en_r`=1), on each edge:
  - If `cnt` == 0: assert `tick` for the next cycle, invert `tog`, reload `cnt` <= `div_r`.
  - Otherwise: `cnt` decrements and `tick` goes to 0.
- Tick period is `div_r`+1 cycles. `tog` period is 2·(`div_r`+1) cycles.
- `div_r` = 0 gives `tick` high every cycle and `tog` at clk/2.
- Stopped channel (`en_r`=0):
  - `cnt` and `tog` are held.
  - `tick` = 0.
- Config write (`cfg_we`=1, `cfg_ch` < NUM_CH):
  - On that edge, `div_r` <= `cfg_div` and `en_r` <= `cfg_en`.
  - A write with `cfg_ch` ≥ NUM_CH is ignored.
- A new divisor does not disturb a count in progress:
  - It applies from the next reload.
  - A reload on the same edge as the write uses the old `div_r`.
- Start, when `en_r` goes 0→1 via a write:
  - `cnt` <= `cfg_div` on that edge, and `tog` is unchanged.
  - First tick follows `cfg_div`+1 edges later.
- Stop, when `en_r` goes 1→0:
  - Takes effect on the write edge.
  - A tick due on that edge is suppressed.
- `sync`=1, for every channel running after this edge's writes:
  - `cnt` <= `div_r`, where `div_r` is the post-write value.
  - `tog` <= 0 and `tick` <= 0.
  - `sync` has priority over a pending terminal-count tick.
- Stopped channels ignore `sync`.
- `running` = `en_r`.

## Timing
- Latency from the edge where `cnt` reaches 0 to the `tick` output: exactly one edge. `tick` and `tog` change on the same edge.
- Config and `sync` are fully synchronous. No handshake: a write is accepted every cycle.
- Asserting `reset` mid-count immediately (asynchronously) clears `tick` and `tog` and reloads `cnt`.
- Deasserting `reset` gives the first tick after DEFAULT_DIV+1 edges.
- Back-to-back writes to the same channel: the last write wins. A divisor written and then overwritten before any reload never takes effect.

## Structure
- Package `clk_enable_pkg` holds:
  - the CNT_W and DEFAULT_DIV defaults;
  - the CH_W width rule;
  - the channel config record type (div, en).
- Sub-module `clk_enable_chan`:
  - holds one channel's `div_r`, `cnt`, `en_r`, `tick`, `tog` and the sync/write/reload priority logic;
  - inputs are `wr` (decoded `cfg_we` with channel select), `cfg_div`, `cfg_en`, `sync`.
- The top level decodes `cfg_ch` and instantiates NUM_CH channels in a generate loop.

## Test plan
- Reset with DEFAULT_DIV overridden to 4: `tick` first high 5 edges after reset release, then every 5 cycles. `tog` period is 10 cycles. `running`=2'b11.
- Write ch0 div=2 while its `cnt`=3: the current period completes with the old value, after which ticks come every 3 cycles. ch1 is unaffected.
- Write ch1 en=0 on its tick edge: that tick is suppressed and `tog` is frozen. Write en=1 div=0: `tick` is continuous one edge later, and `tog` toggles every cycle.
- ch0 div=3 and ch1 div=7 running out of phase, pulse `sync`: both `tog`=0. Ticks coincide 4 cycles later for ch0 and 8 cycles later for ch1. A tick due on the sync edge is suppressed.
- Write with `cfg_ch`=3 and NUM_CH=3: no channel state changes.
- Assert `reset` asynchronously mid-count between edges: `tick`/`tog` drop to 0 before the next edge. The post-release period equals DEFAULT_DIV+1.

Source files
------------

// File: rtl/clk_enable_pkg.sv
// Shared defaults, channel-select width rule and config record for the
// multi-channel clock-enable generator.
package clk_enable_pkg;

  localparam int          CNT_W_DEF       = 28;
  localparam int unsigned DEFAULT_DIV_DEF = 49_999_999;

  // A single channel still needs one select bit on the config port.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  typedef struct packed {
    logic [CNT_W_DEF-1:0] div;
    logic                 en;
  } chan_cfg_t;

endpackage

// File: rtl/clk_enable_gen_if.sv
// Config and enable-output bundle between the generator and its user.
interface clk_enable_gen_if
  import clk_enable_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CNT_W_DEF
);

  localparam int CH_W = ch_width(NUM_CH);

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_en;
  logic              sync;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] tog;
  logic [NUM_CH-1:0] running;

  modport master (
    output cfg_we, cfg_ch, cfg_div, cfg_en, sync,
    input  tick, tog, running
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, cfg_en, sync,
    output tick, tog, running
  );

endinterface

// File: rtl/clk_enable_chan.sv
// One clock-enable channel: divisor, down-counter, run bit, tick pulse and
// toggle level, with stop > sync > start > reload/decrement priority.
module clk_enable_chan
  import clk_enable_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_en,
  input  logic             sync,
  output logic             tick,
  output logic             tog,
  output logic             running
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             en_reg,  en_next;
  logic             tick_reg, tick_next;
  logic             tog_reg,  tog_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg  <= RST_DIV;
      cnt_reg  <= RST_DIV;
      en_reg   <= 1'b1;
      tick_reg <= 1'b0;
      tog_reg  <= 1'b0;
    end else begin
      div_reg  <= div_next;
      cnt_reg  <= cnt_next;
      en_reg   <= en_next;
      tick_reg <= tick_next;
      tog_reg  <= tog_next;
    end
  end

  always_comb begin
    div_next  = wr ? cfg_div : div_reg;
    en_next   = wr ? cfg_en  : en_reg;
    cnt_next  = cnt_reg;
    tog_next  = tog_reg;
    tick_next = 1'b0;

    if (!en_next) begin
      // Stopped (including a stop on this edge): hold count and level.
      cnt_next = cnt_reg;
    end else if (sync) begin
      cnt_next = div_next;
      tog_next = 1'b0;
    end else if (!en_reg) begin
      cnt_next = cfg_div;
    end else if (cnt_reg == '0) begin
      // Reload uses the divisor in force before any write on this edge.
      tick_next = 1'b1;
      tog_next  = ~tog_reg;
      cnt_next  = div_reg;
    end else begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  assign tick    = tick_reg;
  assign tog     = tog_reg;
  assign running = en_reg;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable generator: decodes the config
// port and replicates one channel per output bit.
module clk_enable_gen
  import clk_enable_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  clk_enable_gen_if.slave  bus
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] tick_vec;
  logic [NUM_CH-1:0] tog_vec;
  logic [NUM_CH-1:0] run_vec;

  // Selects at or above NUM_CH match no channel, so such writes vanish.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr;
    assign wr = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

    clk_enable_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr),
      .cfg_div (bus.cfg_div),
      .cfg_en  (bus.cfg_en),
      .sync    (bus.sync),
      .tick    (tick_vec[gi]),
      .tog     (tog_vec[gi]),
      .running (run_vec[gi])
    );
  end

  assign bus.tick    = tick_vec;
  assign bus.tog     = tog_vec;
  assign bus.running = run_vec;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: three channels, DEFAULT_DIV of 4,
// per-edge vector table followed by an asynchronous reset sequence.
module tb_clk_enable_gen;
  import clk_enable_pkg::*;

  localparam int NUM_CH = 3;

  logic clk;
  logic reset;

  clk_enable_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W_DEF)) bus ();

  clk_enable_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W_DEF),
    .DEFAULT_DIV (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic      we;
    logic [1:0] ch;
    chan_cfg_t cfg;
    logic      sync;
    logic [2:0] tick;
    logic [2:0] tog;
    logic [2:0] run;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic we, input logic [1:0] ch, input int div,
                     input logic en, input logic sy, input logic [2:0] tk,
                     input logic [2:0] tg, input logic [2:0] rn);
    vec_t v;
    v.we = we; v.ch = ch; v.cfg.div = CNT_W_DEF'(div); v.cfg.en = en;
    v.sync = sy; v.tick = tk; v.tog = tg; v.run = rn;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [2:0] tk, input logic [2:0] tg);
    add(1'b0, 2'd0, 0, 1'b0, 1'b0, tk, tg, 3'b111);
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_n(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic count_to_tick(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.tick[0] && n < 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Per-edge table, edge k counted from reset release; bits are {ch2,ch1,ch0}.
    for (int k = 1; k <= 4; k++) idle(3'b000, 3'b000);
    idle(3'b111, 3'b111);                                   // E5
    for (int k = 6; k <= 9; k++) idle(3'b000, 3'b111);
    idle(3'b111, 3'b000);                                   // E10
    idle(3'b000, 3'b000);                                   // E11
    add(1'b1, 2'd0, 2, 1'b1, 1'b0, 3'b000, 3'b000, 3'b111); // E12 ch0 div=2 at cnt=3
    idle(3'b000, 3'b000);
    idle(3'b000, 3'b000);
    idle(3'b111, 3'b111);                                   // E15 old period completes
    idle(3'b000, 3'b111);
    idle(3'b000, 3'b111);
    idle(3'b001, 3'b110);                                   // E18 new 3-cycle period
    idle(3'b000, 3'b110);
    idle(3'b110, 3'b000);                                   // E20
    idle(3'b001, 3'b001);                                   // E21
    idle(3'b000, 3'b001);
    idle(3'b000, 3'b001);
    idle(3'b001, 3'b000);                                   // E24
    add(1'b1, 2'd1, 4, 1'b0, 1'b0, 3'b100, 3'b100, 3'b101); // E25 stop ch1 on its tick
    add(1'b0, 2'd0, 0, 1'b0, 1'b0, 3'b000, 3'b100, 3'b101); // E26
    add(1'b1, 2'd1, 0, 1'b1, 1'b0, 3'b001, 3'b101, 3'b111); // E27 start ch1 div=0
    idle(3'b010, 3'b111);                                   // E28
    idle(3'b010, 3'b101);
    idle(3'b111, 3'b010);                                   // E30
    idle(3'b010, 3'b000);
    add(1'b1, 2'd0, 3, 1'b1, 1'b0, 3'b010, 3'b010, 3'b111); // E32 ch0 div=3
    add(1'b1, 2'd1, 7, 1'b1, 1'b0, 3'b011, 3'b001, 3'b111); // E33 ch1 div=7
    idle(3'b010, 3'b011);                                   // E34
    idle(3'b100, 3'b111);
    idle(3'b000, 3'b111);                                   // E36
    add(1'b0, 2'd0, 0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b111); // E37 sync, ch0 tick suppressed
    for (int k = 38; k <= 40; k++) idle(3'b000, 3'b000);
    idle(3'b001, 3'b001);                                   // E41 ch0
    idle(3'b100, 3'b101);                                   // E42 ch2
    idle(3'b000, 3'b101);
    idle(3'b000, 3'b101);
    idle(3'b011, 3'b110);                                   // E45 ch0 and ch1 together
    add(1'b1, 2'd3, 0, 1'b0, 1'b0, 3'b000, 3'b110, 3'b111); // E46 out-of-range select
    idle(3'b100, 3'b010);                                   // E47

    reset = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0;
    bus.cfg_en = 1'b0; bus.sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset tick", bus.tick, 3'b000);
    chk("reset tog", bus.tog, 3'b000);
    chk("reset running", bus.running, 3'b111);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.cfg_we  = vecs[i].we;
      bus.cfg_ch  = vecs[i].ch;
      bus.cfg_div = vecs[i].cfg.div;
      bus.cfg_en  = vecs[i].cfg.en;
      bus.sync    = vecs[i].sync;
      @(posedge clk); #1;
      $display("edge %0d: we=%0b ch=%0d div=%0d en=%0b sync=%0b -> tick=%b tog=%b running=%b",
               i + 1, vecs[i].we, vecs[i].ch, vecs[i].cfg.div, vecs[i].cfg.en,
               vecs[i].sync, bus.tick, bus.tog, bus.running);
      chk($sformatf("edge %0d tick", i + 1), bus.tick, vecs[i].tick);
      chk($sformatf("edge %0d tog", i + 1), bus.tog, vecs[i].tog);
      chk($sformatf("edge %0d running", i + 1), bus.running, vecs[i].run);
      @(negedge clk);
      bus.cfg_we = 1'b0;
      bus.sync   = 1'b0;
    end

    // Mid-cycle asynchronous reset while ch2 tick and ch1 tog are high.
    #1 reset = 1'b1;
    #1;
    $display("async reset: tick=%b tog=%b running=%b", bus.tick, bus.tog, bus.running);
    chk("async reset tick", bus.tick, 3'b000);
    chk("async reset tog", bus.tog, 3'b000);
    chk("async reset running", bus.running, 3'b111);

    @(negedge clk);
    reset = 1'b0;
    count_to_tick(n);
    $display("post-reset first tick after %0d edges: tick=%b tog=%b", n, bus.tick, bus.tog);
    chk_n("post-reset first tick edges", n, 5);
    chk("post-reset first tick", bus.tick, 3'b111);
    chk("post-reset first tog", bus.tog, 3'b111);
    count_to_tick(n);
    $display("post-reset second tick after %0d edges: tick=%b tog=%b", n, bus.tick, bus.tog);
    chk_n("post-reset period", n, 5);
    chk("post-reset second tog", bus.tog, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
